// File: rtl/data_memory_unit.sv
// data_memory_unit: single-port data memory serving the core's M stage.
// After reset a sweep FSM zeroes every word while holding the core off with
// busy. A valid/ready loader port can preload words whenever the core is not
// storing. Core accesses above the implemented depth are dropped or read as
// zero and flagged with a one-cycle addr_err pulse.
module data_memory_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_we,
    input  logic              mem_re,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              addr_err,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic                r_addr_err;
    logic [15:0]         r_wr_count;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_run;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_word_addr;
    logic                w_core_wr;
    logic                w_ld_wr;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;

    assign w_run       = (r_state == S_RUN);
    assign w_in_range  = (mem_addr[15:ADDR_W] == '0);
    assign w_word_addr = mem_addr[ADDR_W-1:0];

    // A core store only commits in RUN and inside the implemented range.
    assign w_core_wr   = w_run & mem_we & w_in_range;

    // The loader yields to any committing core store; an out-of-range store
    // is dropped and therefore does not block the loader.
    assign ld_ready    = w_run & ~(mem_we & w_in_range);
    assign w_ld_wr     = ld_valid & ld_ready;

    // Single write port: the clear sweep owns it in CLEAR, otherwise the core
    // store has priority over the loader.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        w_wr_en   = 1'b0;
        w_wr_addr = w_word_addr;
        w_wr_data = mem_wdata;
        if (!w_run) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_clr_ptr;
            w_wr_data = '0;
        end else if (w_core_wr) begin
            w_wr_en   = 1'b1;
        end else if (w_ld_wr) begin
            w_wr_en   = 1'b1;
            w_wr_addr = ld_addr;
            w_wr_data = ld_data;
        end
    end

    // Clear-sweep FSM: walk clr_ptr across the whole array, then stay in RUN.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
            // All-ones pointer is the last word; leave CLEAR after writing it.
            if (&r_clr_ptr) begin
                r_state <= S_RUN;
            end
        end
    end

    // One-cycle error pulse for a strobed access above the implemented range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_run & (mem_we | mem_re) & ~w_in_range;
        end
    end

    // Saturating count of committed core stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_count <= '0;
        end else if (w_core_wr && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; the clear sweep initialises it instead.
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Asynchronous read returns pre-edge contents, so a same-cycle write is
    // seen as old data until after the edge.
    assign mem_rdata = (w_run & w_in_range) ? r_mem[w_word_addr] : '0;
    assign busy      = ~w_run;
    assign addr_err  = r_addr_err;
    assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed scenarios plus a randomized run checked
// against an array-based reference model of the data memory.
module tb_data_memory_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 256;
    localparam int BOUND  = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              addr_err;
    logic [15:0]       wr_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain array of words and a store counter.
    logic [15:0] m_mem [DEPTH];
    int unsigned m_wr_count;

    always #5 clk = ~clk;

    data_memory_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .addr_err  (addr_err),
        .wr_count  (wr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
        m_wr_count = 0;
    endtask

    // Counts edges until busy drops, bounded so a stuck FSM cannot hang.
    task automatic count_busy(output int cycles);
        cycles = 0;
        while (busy && cycles < BOUND) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        int cycles;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b expected 1", busy); end
        n_vec++;
        if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready: got %b expected 0", ld_ready); end
        n_vec++;
        if (addr_err !== 1'b0) begin n_err++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
        n_vec++;
        if (wr_count !== 16'h0000) begin n_err++; $display("FAIL reset_wr_count: got %h expected 0000", wr_count); end
        n_vec++;
        if (mem_rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rdata: got %h expected 0000", mem_rdata); end
        rst = 1'b0;
        model_reset();
        count_busy(cycles);
        n_vec++;
        if (cycles != DEPTH) begin n_err++; $display("FAIL reset_clear_len: got %0d cycles expected %0d", cycles, DEPTH); end
        for (int a = 0; a < DEPTH; a++) begin
            mem_addr = 16'(a);
            #1;
            n_vec++;
            if (mem_rdata !== m_mem[a]) begin
                n_err++;
                $display("FAIL reset_zero_read: addr %h got %h expected %h", a, mem_rdata, m_mem[a]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_store_read();
        mem_addr  = 16'h0012;
        mem_wdata = 16'hBEEF;
        mem_we    = 1'b1;
        #1;
        n_vec++;
        if (mem_rdata !== 16'h0000) begin n_err++; $display("FAIL rdw_old_data: got %h expected 0000", mem_rdata); end
        n_vec++;
        if (ld_ready !== 1'b0) begin n_err++; $display("FAIL rdw_ld_ready: got %b expected 0", ld_ready); end
        m_mem[8'h12] = 16'hBEEF;
        m_wr_count++;
        tick();
        mem_we = 1'b0;
        #1;
        n_vec++;
        if (mem_rdata !== 16'hBEEF) begin n_err++; $display("FAIL store_new_data: got %h expected BEEF", mem_rdata); end
        n_vec++;
        if (wr_count !== 16'd1) begin n_err++; $display("FAIL store_wr_count: got %0d expected 1", wr_count); end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        mem_addr  = 16'h0100;
        mem_wdata = 16'hDEAD;
        mem_we    = 1'b1;
        #1;
        n_vec++;
        if (mem_rdata !== 16'h0000) begin n_err++; $display("FAIL oor_store_rdata: got %h expected 0000", mem_rdata); end
        n_vec++;
        if (ld_ready !== 1'b1) begin n_err++; $display("FAIL oor_store_ld_ready: got %b expected 1", ld_ready); end
        tick();
        mem_we   = 1'b0;
        mem_addr = 16'h0000;
        #1;
        n_vec++;
        if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_store_err: got %b expected 1", addr_err); end
        n_vec++;
        if (mem_rdata !== m_mem[0]) begin n_err++; $display("FAIL oor_store_alias: got %h expected %h", mem_rdata, m_mem[0]); end
        n_vec++;
        if (wr_count !== 16'(m_wr_count)) begin n_err++; $display("FAIL oor_store_count: got %0d expected %0d", wr_count, m_wr_count); end
        tick();
        n_vec++;
        if (addr_err !== 1'b0) begin n_err++; $display("FAIL oor_store_pulse: got %b expected 0", addr_err); end
        mem_addr = 16'h0100;
        mem_re   = 1'b1;
        #1;
        n_vec++;
        if (mem_rdata !== 16'h0000) begin n_err++; $display("FAIL oor_load_rdata: got %h expected 0000", mem_rdata); end
        tick();
        mem_re   = 1'b0;
        mem_addr = 16'hFF00;
        n_vec++;
        if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_load_err: got %b expected 1", addr_err); end
        tick();
        n_vec++;
        if (addr_err !== 1'b0) begin n_err++; $display("FAIL oor_load_pulse: got %b expected 0", addr_err); end
        tick();
        n_vec++;
        if (addr_err !== 1'b0) begin n_err++; $display("FAIL oor_no_strobe: got %b expected 0", addr_err); end
        idle_inputs();
    endtask

    task automatic test_loader_contention();
        ld_valid  = 1'b1;
        ld_addr   = 8'h05;
        ld_data   = 16'h1234;
        mem_addr  = 16'h0007;
        mem_wdata = 16'hCAFE;
        mem_we    = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (ld_ready !== 1'b0) begin n_err++; $display("FAIL contend_ld_ready: cycle %0d got %b expected 0", c, ld_ready); end
            m_mem[8'h07] = 16'hCAFE;
            m_wr_count++;
            tick();
        end
        mem_we   = 1'b0;
        mem_addr = 16'h0005;
        #1;
        n_vec++;
        if (ld_ready !== 1'b1) begin n_err++; $display("FAIL contend_ld_accept: got %b expected 1", ld_ready); end
        n_vec++;
        if (mem_rdata !== m_mem[8'h05]) begin n_err++; $display("FAIL ld_rdw_old: got %h expected %h", mem_rdata, m_mem[8'h05]); end
        m_mem[8'h05] = 16'h1234;
        tick();
        ld_valid = 1'b0;
        #1;
        n_vec++;
        if (mem_rdata !== 16'h1234) begin n_err++; $display("FAIL ld_word: got %h expected 1234", mem_rdata); end
        mem_addr = 16'h0007;
        #1;
        n_vec++;
        if (mem_rdata !== 16'hCAFE) begin n_err++; $display("FAIL contend_core_word: got %h expected CAFE", mem_rdata); end
        n_vec++;
        if (wr_count !== 16'(m_wr_count)) begin n_err++; $display("FAIL contend_count: got %0d expected %0d", wr_count, m_wr_count); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic        pend;
        logic        in_r;
        logic        exp_err;
        logic        exp_rdy;
        logic [15:0] exp_rd;
        pend = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend    = 1'b1;
                ld_addr = 8'($urandom_range(0, 15));
                ld_data = 16'($urandom);
            end
            ld_valid  = pend;
            mem_we    = 1'($urandom_range(0, 1));
            mem_re    = 1'($urandom_range(0, 1));
            mem_wdata = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       mem_addr = 16'($urandom);
                1, 2:    mem_addr = 16'($urandom_range(0, 255));
                default: mem_addr = 16'($urandom_range(0, 15));
            endcase
            #1;
            in_r    = (mem_addr < 16'd256);
            exp_rd  = in_r ? m_mem[mem_addr[7:0]] : 16'h0000;
            exp_rdy = !(mem_we && in_r);
            n_vec++;
            if (mem_rdata !== exp_rd) begin
                n_err++;
                $display("FAIL rand_rdata: addr %h got %h expected %h", mem_addr, mem_rdata, exp_rd);
            end
            n_vec++;
            if (ld_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL rand_ld_ready: got %b expected %b", ld_ready, exp_rdy);
            end
            exp_err = (mem_we || mem_re) && !in_r;
            if (mem_we && in_r) begin
                m_mem[mem_addr[7:0]] = mem_wdata;
                if (m_wr_count < 32'hFFFF) m_wr_count++;
            end else if (pend) begin
                m_mem[ld_addr] = ld_data;
                pend = 1'b0;
            end
            tick();
            n_vec++;
            if (addr_err !== exp_err) begin
                n_err++;
                $display("FAIL rand_addr_err: got %b expected %b", addr_err, exp_err);
            end
            n_vec++;
            if (wr_count !== 16'(m_wr_count)) begin
                n_err++;
                $display("FAIL rand_wr_count: got %0d expected %0d", wr_count, m_wr_count);
            end
        end
        idle_inputs();
        #1;
        for (int a = 0; a < 16; a++) begin
            mem_addr = 16'(a);
            #1;
            n_vec++;
            if (mem_rdata !== m_mem[a]) begin
                n_err++;
                $display("FAIL rand_final: addr %h got %h expected %h", a, mem_rdata, m_mem[a]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear();
        int cycles;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 100; c++) tick();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL midclr_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL midclr_busy_rst: got %b expected 1", busy); end
        n_vec++;
        if (wr_count !== 16'h0000) begin n_err++; $display("FAIL midclr_wr_count: got %0d expected 0", wr_count); end
        tick();
        tick();
        rst = 1'b0;
        count_busy(cycles);
        n_vec++;
        if (cycles != DEPTH) begin n_err++; $display("FAIL midclr_len: got %0d cycles expected %0d", cycles, DEPTH); end
        for (int a = 0; a < DEPTH; a += 5) begin
            mem_addr = 16'(a);
            #1;
            n_vec++;
            if (mem_rdata !== m_mem[a]) begin
                n_err++;
                $display("FAIL midclr_zero: addr %h got %h expected %h", a, mem_rdata, m_mem[a]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_loader_during_clear();
        int cycles;
        rst = 1'b1;
        tick();
        ld_valid = 1'b1;
        ld_addr  = 8'h33;
        ld_data  = 16'h5A5A;
        #1;
        n_vec++;
        if (ld_ready !== 1'b0) begin n_err++; $display("FAIL ldclr_rst_ready: got %b expected 0", ld_ready); end
        rst = 1'b0;
        model_reset();
        cycles = 0;
        while (busy && cycles < BOUND) begin
            n_vec++;
            if (ld_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ldclr_ready: cycle %0d got %b expected 0", cycles, ld_ready);
            end
            tick();
            cycles++;
        end
        ld_valid = 1'b0;
        n_vec++;
        if (cycles != DEPTH) begin n_err++; $display("FAIL ldclr_len: got %0d cycles expected %0d", cycles, DEPTH); end
        mem_addr = 16'h0033;
        #1;
        n_vec++;
        if (mem_rdata !== m_mem[8'h33]) begin n_err++; $display("FAIL ldclr_word: got %h expected %h", mem_rdata, m_mem[8'h33]); end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_store_read();
        test_out_of_range();
        test_loader_contention();
        test_random();
        test_reset_mid_clear();
        test_loader_during_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
